// File: rtl/seg_pkg.sv
// Shared seven-segment constants: a..g hex patterns (active-high) and bit positions
// of the 8-bit bus. The encoder and the capture decoder both use this table.
package seg_pkg;

    localparam int SEG_BIT_A  = 7;
    localparam int SEG_BIT_G  = 1;
    localparam int SEG_BIT_DP = 0;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Indexed by hex value; entry 0 sits in the least significant slot.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h73, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

endpackage

// File: rtl/seg_capture_if.sv
// Display-capture bus: sampled segment/select inputs, error clear, and the
// decoded per-digit register file with its update strobe.
interface seg_capture_if #(
    parameter int NDIG = 8
);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [7:0]        i_seg;
    logic [NDIG-1:0]   i_an;
    logic              i_clr;
    logic [4*NDIG-1:0] o_digits;
    logic [NDIG-1:0]   o_valid;
    logic [NDIG-1:0]   o_dp;
    logic [NDIG-1:0]   o_err;
    logic              o_upd;
    logic [IDXW-1:0]   o_idx;

    modport master (
        output i_seg, i_an, i_clr,
        input  o_digits, o_valid, o_dp, o_err, o_upd, o_idx
    );

    modport slave (
        input  i_seg, i_an, i_clr,
        output o_digits, o_valid, o_dp, o_err, o_upd, o_idx
    );

endinterface

// File: rtl/seg_decode.sv
// Combinational a..g pattern to hex lookup; flags a match and the all-off blank.
module seg_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic       blank,
    output logic [3:0] value
);

    always_comb begin
        hit   = 1'b0;
        value = 4'h0;
        for (int v = 0; v < 16; v++) begin
            if (seg == SEG_HEX[v]) begin
                hit   = 1'b1;
                value = 4'(v);
            end
        end
        blank = (seg == SEG_BLANK);
    end

endmodule

// File: rtl/seg_capture.sv
// Samples a multiplexed active-low segment bus, waits for a stable one-hot
// (segment, select) pair, then decodes it into a per-digit register file.
module seg_capture
    import seg_pkg::*;
#(
    parameter int NDIG   = 8,
    parameter int STABLE = 4
) (
    input logic          clk,
    input logic          rst,
    seg_capture_if.slave bus
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int RUNW = 4;
    localparam logic [RUNW-1:0] RUN_MAX = RUNW'(STABLE);

    logic [7:0]           seg_m, seg_s;
    logic [NDIG-1:0]      an_m, an_s;
    logic [RUNW-1:0]      run, run_nxt;
    logic                 acc, acc_nxt;
    logic                 one_hot, changed;
    logic [IDXW-1:0]      cur_idx;
    logic [6:0]           pat;
    logic                 hit, blank;
    logic [3:0]           value;
    logic [NDIG-1:0][3:0] digits;
    logic [NDIG-1:0]      valid, dp, err;
    logic                 upd;
    logic [IDXW-1:0]      idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m <= '0;
            an_m  <= '0;
            seg_s <= '0;
            an_s  <= '0;
            run   <= '0;
            acc   <= 1'b0;
        end else begin
            seg_m <= bus.i_seg;
            an_m  <= bus.i_an;
            seg_s <= seg_m;
            an_s  <= an_m;
            run   <= run_nxt;
            acc   <= acc_nxt;
        end
    end

    // seg_m/an_m is the sample about to become S; compare it against current S.
    always_comb begin
        one_hot = (an_m != '0) && ((an_m & (an_m - NDIG'(1))) == '0);
        changed = (seg_m != seg_s) || (an_m != an_s);
        run_nxt = '0;
        if (one_hot) begin
            if (changed)
                run_nxt = RUNW'(1);
            else if (run < RUN_MAX)
                run_nxt = run + RUNW'(1);
            else
                run_nxt = run;
        end
        // 'changed' keeps STABLE=1 working when patterns swap back to back.
        acc_nxt = one_hot && (run_nxt == RUN_MAX) && (changed || (run != RUN_MAX));
    end

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NDIG; i++)
            if (an_s[i]) cur_idx = IDXW'(i);
    end

    assign pat = ~seg_s[SEG_BIT_A:SEG_BIT_G];

    seg_decode u_decode (
        .seg   (pat),
        .hit   (hit),
        .blank (blank),
        .value (value)
    );

    // S still holds the accepted pattern on the edge after acc rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
            valid  <= '0;
            dp     <= '0;
            err    <= '0;
            upd    <= 1'b0;
            idx    <= '0;
        end else begin
            upd <= acc;
            if (bus.i_clr)
                err <= '0;
            if (acc) begin
                idx <= cur_idx;
                if (hit) begin
                    digits[cur_idx] <= value;
                    valid[cur_idx]  <= 1'b1;
                    dp[cur_idx]     <= ~seg_s[SEG_BIT_DP];
                end else if (blank) begin
                    valid[cur_idx]  <= 1'b0;
                    dp[cur_idx]     <= ~seg_s[SEG_BIT_DP];
                end else begin
                    valid[cur_idx]  <= 1'b0;
                    err[cur_idx]    <= 1'b1;
                end
            end
        end
    end

    assign bus.o_digits = digits;
    assign bus.o_valid  = valid;
    assign bus.o_dp     = dp;
    assign bus.o_err    = err;
    assign bus.o_upd    = upd;
    assign bus.o_idx    = idx;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus random traffic, checked each
// cycle against a sample-history model of the capture rules.
module tb_seg_capture;

    localparam int NDIG   = 8;
    localparam int STABLE = 4;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct packed {
        logic [7:0]      seg;
        logic [NDIG-1:0] an;
    } smp_t;

    logic clk = 1'b0;
    logic rst;

    seg_capture_if #(.NDIG(NDIG)) bus ();

    seg_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;

    smp_t                 h[$];
    logic [NDIG-1:0][3:0] m_dig;
    logic [NDIG-1:0]      m_val, m_dp, m_err;
    logic                 m_upd;
    logic [2:0]           m_idx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input int v, input logic dpv);
        logic [6:0] p;
        p = HEX_TAB[v];
        return ~{p, dpv};
    endfunction

    function automatic logic is_onehot(input logic [NDIG-1:0] a);
        int n;
        n = 0;
        for (int i = 0; i < NDIG; i++) if (a[i]) n++;
        return n == 1;
    endfunction

    task automatic model_reset();
        h.delete();
        for (int i = 0; i < STABLE + 3; i++) h.push_back('0);
        m_dig = '0; m_val = '0; m_dp = '0; m_err = '0; m_upd = 1'b0; m_idx = '0;
    endtask

    // A sample becomes S one edge after it is presented; acceptance shows on the
    // edge after S has matched for STABLE samples, and only on the first such edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                int n, d, val;
                smp_t w;
                logic acc, found;
                logic [6:0] p;
                h.push_back({bus.i_seg, bus.i_an});
                n = h.size() - 1;
                w = h[n-2];
                acc = is_onehot(w.an);
                for (int k = 1; k < STABLE; k++) if (h[n-2-k] != w) acc = 1'b0;
                if (h[n-2-STABLE] == w) acc = 1'b0;
                if (bus.i_clr) m_err = '0;
                m_upd = acc;
                if (acc) begin
                    d = 0;
                    for (int i = 0; i < NDIG; i++) if (w.an[i]) d = i;
                    m_idx = 3'(d);
                    p = ~w.seg[7:1];
                    found = 1'b0;
                    val = 0;
                    for (int v = 0; v < 16; v++) if (HEX_TAB[v] == p) begin found = 1'b1; val = v; end
                    if (found) begin
                        m_dig[d] = 4'(val); m_val[d] = 1'b1; m_dp[d] = ~w.seg[0];
                    end else if (p == 7'h00) begin
                        m_val[d] = 1'b0; m_dp[d] = ~w.seg[0];
                    end else begin
                        m_val[d] = 1'b0; m_err[d] = 1'b1;
                    end
                end
                if (h.size() > 64) void'(h.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("digits", 64'(bus.o_digits), 64'(m_dig));
                chk("valid",  64'(bus.o_valid),  64'(m_val));
                chk("dp",     64'(bus.o_dp),     64'(m_dp));
                chk("err",    64'(bus.o_err),    64'(m_err));
                chk("upd",    64'(bus.o_upd),    64'(m_upd));
                chk("idx",    64'(bus.o_idx),    64'(m_idx));
                if (bus.o_upd) upd_cnt++;
            end
        end
    end

    task automatic hold(input logic [7:0] s, input logic [NDIG-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_seg = s;
            bus.i_an  = a;
        end
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.i_seg = 8'hFF;
        bus.i_an  = '0;
        bus.i_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_digits", 64'(bus.o_digits), 64'h0);
        chk("rst_valid",  64'(bus.o_valid),  64'h0);
        chk("rst_upd",    64'(bus.o_upd),    64'h0);
        rst = 1'b0;

        base = upd_cnt;
        hold(8'h0D, 8'h04, 10); #1;
        chk("single_upd_count", 64'(upd_cnt - base), 64'd1);
        chk("single_idx",       64'(bus.o_idx), 64'd2);
        chk("single_digit2",    64'(bus.o_digits[11:8]), 64'd3);
        chk("single_valid2",    64'(bus.o_valid[2]), 64'd1);
        chk("single_err",       64'(bus.o_err), 64'd0);

        base = upd_cnt;
        hold(8'h11, 8'h01, 3);
        hold(8'h03, 8'h01, 10); #1;
        chk("glitch_upd_count", 64'(upd_cnt - base), 64'd1);
        chk("glitch_digit0",    64'(bus.o_digits[3:0]), 64'd0);
        chk("glitch_valid0",    64'(bus.o_valid[0]), 64'd1);
        chk("glitch_dp0",       64'(bus.o_dp[0]), 64'd0);

        hold(8'h02, 8'h80, 8); #1;
        chk("dp_digit7", 64'(bus.o_digits[31:28]), 64'd0);
        chk("dp_dp7",    64'(bus.o_dp[7]), 64'd1);
        chk("dp_valid7", 64'(bus.o_valid[7]), 64'd1);

        hold(8'h49, 8'h02, 8); #1;
        chk("five_digit1", 64'(bus.o_digits[7:4]), 64'd5);
        hold(8'hFF, 8'h02, 8); #1;
        chk("blank_valid1", 64'(bus.o_valid[1]), 64'd0);
        chk("blank_err",    64'(bus.o_err), 64'd0);
        hold(8'h7F, 8'h02, 8); #1;
        chk("bad_err",    64'(bus.o_err), 64'h02);
        chk("bad_digit1", 64'(bus.o_digits[7:4]), 64'd5);
        @(negedge clk); bus.i_clr = 1'b1;
        @(negedge clk); bus.i_clr = 1'b0; #1;
        chk("clr_err", 64'(bus.o_err), 64'd0);

        base = upd_cnt;
        hold(8'h0D, 8'h00, 20);
        hold(8'h0D, 8'h03, 20); #1;
        chk("illegal_upd_count", 64'(upd_cnt - base), 64'd0);

        hold(8'h25, 8'h08, 3);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_digits", 64'(bus.o_digits), 64'h0);
        chk("midrst_valid",  64'(bus.o_valid),  64'h0);
        chk("midrst_dp",     64'(bus.o_dp),     64'h0);
        chk("midrst_err",    64'(bus.o_err),    64'h0);
        chk("midrst_upd",    64'(bus.o_upd),    64'h0);
        rst = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 0; d < NDIG; d++)
                hold(enc(pass * 8 + d, 1'b0), NDIG'(1) << d, 7);
            #1;
            for (int d = 0; d < NDIG; d++)
                chk($sformatf("scan_p%0d_d%0d", pass, d), 64'(bus.o_digits[4*d +: 4]), 64'(pass * 8 + d));
            chk($sformatf("scan_p%0d_valid", pass), 64'(bus.o_valid), 64'hFF);
        end

        for (int it = 0; it < 250; it++) begin
            logic [7:0] s;
            logic [NDIG-1:0] a;
            int len, sel;
            sel = $urandom_range(0, 19);
            if (sel < 12)      s = enc($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else if (sel < 15) s = {7'h7F, 1'($urandom_range(0, 1))};
            else               s = 8'($urandom);
            if ($urandom_range(0, 9) < 8) a = NDIG'(1) << $urandom_range(0, NDIG - 1);
            else                          a = NDIG'($urandom);
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                bus.i_seg = s;
                bus.i_an  = a;
                bus.i_clr = ($urandom_range(0, 19) == 0);
            end
        end
        @(negedge clk); bus.i_clr = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
# seg_capture

Seven-segment display capture: the decode side of the `seg` hex-to-segment encoder. It samples a time-multiplexed, active-low segment bus and its digit-select lines, and filters out glitches and ghosting during digit switching. It then decodes each stable pattern back to a 4-bit hex value and keeps a per-digit register file. It sits on the display loopback or test path and lets self-check logic read back what the display is actually showing.

## Interface
- `NDIG`, default 8: number of multiplexed digits.
- `STABLE`, default 4: consecutive sampled cycles a (segment, select) pair must hold before it is accepted; legal range 1..15.
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `i_seg` input, 8 bits: active-low segments; bit7..bit1 = a..g, bit0 = dp.
- `i_an` input, `NDIG` bits: digit select, active-high, must be one-hot to be meaningful.
- `i_clr` input, 1 bit: synchronous clear of all `o_err` bits.
- `o_digits` output, 4·`NDIG` bits: decoded value; digit d occupies bits [4d+3:4d].
- `o_valid` output, `NDIG` bits: digit d holds a decoded hex value.
- `o_dp` output, `NDIG` bits: last accepted decimal point per digit.
- `o_err` output, `NDIG` bits: sticky flag; an unrecognised pattern was accepted on digit d.
- `o_upd` output, 1 bit: one-cycle pulse when an acceptance happens.
- `o_idx` output, clog2(`NDIG`) bits: digit index of the latest acceptance.

## Operation
- **Input synchronizer:** `i_seg` and `i_an` pass through a 2-flop synchronizer. Stage 2 is the sample S.
- **Run counter (`run`):** at each edge, if S (new) equals S (previous) and `i_an` in S is one-hot, `run` increments, saturating at `STABLE`. If S differs but is one-hot, `run` = 1. If not one-hot (zero or multiple bits), `run` = 0.
- **Acceptance:** occurs on the edge where `run` transitions to `STABLE`. It fires exactly once per stable run; a held pattern is never re-accepted.
- **Decode:** invert the segments; a..g are matched against the 16 hex patterns (a..g active-high):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=73, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - dp is ignored for matching.
- **On acceptance at digit d** (the index of the one-hot `i_an`):
  - Match: `o_digits[d]` = value, `o_valid[d]` = 1, `o_dp[d]` = dp.
  - All segments off (blank): `o_valid[d]` = 0, `o_dp[d]` = dp, value kept, no error.
  - Any other pattern: `o_valid[d]` = 0, `o_err[d]` = 1, value kept.
  - In all three cases `o_upd` = 1 and `o_idx` = d.
- **Error clearing:** `i_clr` clears all `o_err` bits. If an error is set on the same edge, the new error wins for that digit.
- **Reset:** every output and internal register goes to 0, including both synchronizer stages and `run`. Reset mid-run discards the partial run.

## Timing
- A pattern presented before edge 0 reaches S at edge 1, with `run` = 1.
- Acceptance lands at edge `STABLE`+1: `o_digits`, `o_valid`, `o_dp`, `o_err`, `o_upd`, and `o_idx` all update on that edge. `o_upd` is high for that one cycle only.
- Any change of `i_seg` or `i_an` before acceptance restarts the count.
- A pattern held for fewer than `STABLE` samples is never accepted.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Package `seg_pkg`:** holds the 16 active-high a..g patterns as constants indexed by value, `SEG_BLANK` = 7'h00, and the segment bit-position constants. The existing encoder can share these constants.
- **Sub-module `seg_decode`:** purely combinational. Takes 7 bits of a..g and returns {hit, blank, value[3:0]}.
- **Top level:** `seg_capture` holds the synchronizer, run counter, and per-digit registers.

## Test plan
- **Single digit:** `NDIG`=8, `STABLE`=4; `i_an`=8'h04, `i_seg`=8'h0D held 10 cycles → one `o_upd`, `o_idx`=2, `o_digits[11:8]`=3, `o_valid[2]`=1, `o_err`=0.
- **Glitch rejection:** `i_an`=8'h01, `i_seg`=8'h11 for 3 cycles, then 8'h03 held → no update for the 8'h11 run; digit 0 = 0, `o_dp[0]`=0.
- **Decimal point:** `i_seg`=8'h02 on `i_an`=8'h80 → `o_digits[31:28]`=0, `o_dp[7]`=1, `o_valid[7]`=1.
- **Blank and error:** blank 8'hFF on digit 1 → `o_valid[1]`=0, no error. Then 8'h7F (segment a only) → `o_err[1]`=1, value unchanged. Then `i_clr` pulse → `o_err`=0.
- **Illegal select:** `i_an`=8'h00 and `i_an`=8'h03 each held 20 cycles → no `o_upd`.
- **Reset mid-run:** `rst` pulse after 2 stable cycles → all outputs 0. A full 8-digit scan cycling codes 0..F afterwards → all 16 values decode correctly across two passes.
